// File: rtl/ad_upack.sv
// Stream unpacker: accepts I_W-unit words and emits O_W-unit words in unit order.
// Unit 0 is in the LSBs and leaves first; a unit buffer absorbs rate mismatch.
module ad_upack #(
    parameter int unsigned I_W    = 6,
    parameter int unsigned O_W    = 4,
    parameter int unsigned UNIT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [I_W*UNIT_W-1:0]   idata,
    input  logic                    ivalid,
    output logic                    iready,
    output logic [O_W*UNIT_W-1:0]   odata,
    output logic                    ovalid,
    input  logic                    oready
);

    localparam int unsigned BUF_U = 2 * (I_W + O_W);
    localparam int unsigned CNT_W = $clog2(BUF_U + 1);
    localparam int unsigned BUF_W = BUF_U * UNIT_W;
    localparam int unsigned IN_W  = I_W * UNIT_W;
    localparam int unsigned OUT_W = O_W * UNIT_W;

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] ins_data;
    logic [BUF_W-1:0] ins_mask;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             ifire;
    logic             ofire;

    // Handshake flags depend on registered state only, so no ready/valid loops through us.
    assign iready = (cnt_q <= CNT_W'(BUF_U - I_W));
    assign ovalid = (cnt_q >= CNT_W'(O_W));
    assign odata  = buf_q[OUT_W-1:0];
    assign ifire  = ivalid & iready;
    assign ofire  = ovalid & oready;

    // Drain first, then append the new word right after whatever remains.
    always_comb begin
        shifted  = buf_q;
        cnt_base = cnt_q;
        if (ofire) begin
            shifted  = buf_q >> OUT_W;
            cnt_base = cnt_q - CNT_W'(O_W);
        end
        ins_data = BUF_W'(idata) << (32'(cnt_base) * UNIT_W);
        ins_mask = BUF_W'({IN_W{1'b1}}) << (32'(cnt_base) * UNIT_W);
        buf_d    = shifted;
        cnt_d    = cnt_base;
        if (ifire) begin
            buf_d = (shifted & ~ins_mask) | ins_data;
            cnt_d = cnt_base + CNT_W'(I_W);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ad_upack.sv
// Directed and random-stall bench for ad_upack across three I_W/O_W ratios.
// Instance 0 is 6->4, instance 1 is 4->6, instance 2 is 4->4.
module tb_ad_upack;

    logic        clk;
    logic        reset;
    logic [47:0] idata_v  [3];
    logic        ivalid_v [3];
    logic        oready_v [3];
    logic        iready_v [3];
    logic        ovalid_v [3];
    logic [47:0] odata_v  [3];
    logic [31:0] odata_a;
    logic [47:0] odata_b;
    logic [31:0] odata_c;

    logic [7:0]  src [1040];
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ad_upack #(.I_W(6), .O_W(4), .UNIT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .idata(idata_v[0]), .ivalid(ivalid_v[0]), .iready(iready_v[0]),
        .odata(odata_a), .ovalid(ovalid_v[0]), .oready(oready_v[0])
    );

    ad_upack #(.I_W(4), .O_W(6), .UNIT_W(8)) dut_b (
        .clk(clk), .reset(reset),
        .idata(idata_v[1][31:0]), .ivalid(ivalid_v[1]), .iready(iready_v[1]),
        .odata(odata_b), .ovalid(ovalid_v[1]), .oready(oready_v[1])
    );

    ad_upack #(.I_W(4), .O_W(4), .UNIT_W(8)) dut_c (
        .clk(clk), .reset(reset),
        .idata(idata_v[2][31:0]), .ivalid(ivalid_v[2]), .iready(iready_v[2]),
        .odata(odata_c), .ovalid(ovalid_v[2]), .oready(oready_v[2])
    );

    assign odata_v[0] = {16'h0, odata_a};
    assign odata_v[1] = odata_b;
    assign odata_v[2] = {16'h0, odata_c};

    function automatic int iw_of(input int s);
        return (s == 0) ? 6 : 4;
    endfunction

    function automatic int ow_of(input int s);
        return (s == 1) ? 6 : 4;
    endfunction

    // Word of n units taken from src starting at unit index base.
    function automatic logic [47:0] units_at(input int base, input int n);
        logic [47:0] w;
        w = '0;
        for (int u = 0; u < n; u++) w[u*8 +: 8] = src[base + u];
        return w;
    endfunction

    task automatic idle_all();
        for (int s = 0; s < 3; s++) begin
            ivalid_v[s] = 1'b0;
            oready_v[s] = 1'b0;
            idata_v[s]  = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_all();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            ivalid_v[s] = 1'b1;
            oready_v[s] = 1'b1;
            idata_v[s]  = 48'hDEAD_BEEF_CAFE;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ovalid_v[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ovalid s=%0d got=%b exp=0", s, ovalid_v[s]);
            end
            checks++;
            if (iready_v[s] !== 1'b1) begin
                failures++;
                $display("FAIL reset_iready s=%0d got=%b exp=1", s, iready_v[s]);
            end
            checks++;
            if (odata_v[s] !== 48'h0) begin
                failures++;
                $display("FAIL reset_odata s=%0d got=%h exp=0", s, odata_v[s]);
            end
        end
        idle_all();
        reset = 1'b1;
    endtask

    // Streams nwords words into instance s and checks every output word in order.
    task automatic run_stream(input int s, input int nwords, input bit rnd, input string name);
        int iw;
        int ow;
        int wi;
        int got;
        int target;
        int cycles;
        logic [47:0] exp;
        iw     = iw_of(s);
        ow     = ow_of(s);
        wi     = 0;
        got    = 0;
        cycles = 0;
        target = (nwords * iw) / ow;
        while (got < target && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            ivalid_v[s] = (wi < nwords) && (rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
            idata_v[s]  = (wi < nwords) ? units_at(wi * iw, iw) : 48'h0;
            oready_v[s] = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (ivalid_v[s] && iready_v[s]) wi++;
            if (ovalid_v[s] && oready_v[s]) begin
                exp = units_at(got * ow, ow);
                checks++;
                if (odata_v[s] !== exp) begin
                    failures++;
                    $display("FAIL %s s=%0d word=%0d got=%h exp=%h", name, s, got, odata_v[s], exp);
                end
                got++;
            end
        end
        checks++;
        if (got != target) begin
            failures++;
            $display("FAIL %s_count s=%0d got=%0d exp=%0d", name, s, got, target);
        end
        // Once primed, a 1:1 unpacker moves one word per cycle.
        if (s == 2 && !rnd) begin
            checks++;
            if (cycles != nwords + 1) begin
                failures++;
                $display("FAIL %s_rate s=%0d got=%0d cycles exp=%0d", name, s, cycles, nwords + 1);
            end
        end
        @(negedge clk);
        ivalid_v[s] = 1'b0;
        oready_v[s] = 1'b0;
    endtask

    task automatic test_ordering();
        for (int i = 0; i < 1040; i++) src[i] = 8'(i);
        for (int s = 0; s < 3; s++) begin
            apply_reset();
            run_stream(s, (s == 1) ? 6 : 4, 1'b0, "ordering");
        end
    endtask

    task automatic test_soak();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1040; i++) src[i] = 8'($urandom);
            apply_reset();
            run_stream(s, (1024 + iw_of(s) - 1) / iw_of(s), 1'b1, "soak");
        end
    endtask

    task automatic test_backpressure();
        int acc;
        for (int i = 0; i < 1040; i++) src[i] = 8'(i);
        apply_reset();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ivalid_v[0] = 1'b1;
            oready_v[0] = 1'b0;
            idata_v[0]  = units_at(acc * 6, 6);
            if (iready_v[0]) acc++;
        end
        checks++;
        if (acc != 3) begin
            failures++;
            $display("FAIL bp_accepted got=%0d exp=3", acc);
        end
        @(negedge clk);
        ivalid_v[0] = 1'b0;
        oready_v[0] = 1'b1;
        checks++;
        if (iready_v[0] !== 1'b0 || ovalid_v[0] !== 1'b1 || odata_v[0] !== 48'h0000_0302_0100) begin
            failures++;
            $display("FAIL bp_full iready=%b ovalid=%b odata=%h exp 0/1/03020100",
                     iready_v[0], ovalid_v[0], odata_v[0]);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (odata_v[0] !== units_at(k * 4, 4) || ovalid_v[0] !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain k=%0d got=%h exp=%h", k, odata_v[0], units_at(k * 4, 4));
            end
            if (k == 1) begin
                checks++;
                if (iready_v[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_iready_back got=%b exp=1", iready_v[0]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (ovalid_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_residue_ovalid got=%b exp=0", ovalid_v[0]);
        end
        oready_v[0] = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 1040; i++) src[i] = 8'(i);
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ivalid_v[0] = 1'b1;
            oready_v[0] = 1'b0;
            idata_v[0]  = units_at(c * 6, 6);
        end
        @(negedge clk);
        ivalid_v[0] = 1'b0;
        oready_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (odata_v[0] !== 48'h0000_0706_0504 || iready_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL sim_pre odata=%h iready=%b exp 07060504/1", odata_v[0], iready_v[0]);
        end
        ivalid_v[0] = 1'b1;
        idata_v[0]  = units_at(18, 6);
        for (int k = 2; k < 6; k++) begin
            @(negedge clk);
            ivalid_v[0] = 1'b0;
            checks++;
            if (odata_v[0] !== units_at(k * 4, 4) || ovalid_v[0] !== 1'b1) begin
                failures++;
                $display("FAIL sim_word k=%0d got=%h exp=%h", k, odata_v[0], units_at(k * 4, 4));
            end
        end
        @(negedge clk);
        checks++;
        if (ovalid_v[0] !== 1'b0 || iready_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL sim_empty ovalid=%b iready=%b exp 0/1", ovalid_v[0], iready_v[0]);
        end
        oready_v[0] = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) src[i] = 8'(8'h10 + i);
        apply_reset();
        @(negedge clk);
        ivalid_v[0] = 1'b1;
        oready_v[0] = 1'b0;
        idata_v[0]  = units_at(0, 6);
        @(negedge clk);
        ivalid_v[0] = 1'b0;
        checks++;
        if (ovalid_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL mr_primed ovalid=%b exp=1", ovalid_v[0]);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ovalid_v[0] !== 1'b0 || iready_v[0] !== 1'b1 || odata_v[0] !== 48'h0) begin
            failures++;
            $display("FAIL mr_async ovalid=%b iready=%b odata=%h exp 0/1/0",
                     ovalid_v[0], iready_v[0], odata_v[0]);
        end
        ivalid_v[0] = 1'b1;
        idata_v[0]  = 48'h5555_5555_5555;
        repeat (2) @(negedge clk);
        checks++;
        if (ovalid_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL mr_ignore ovalid=%b exp=0", ovalid_v[0]);
        end
        ivalid_v[0] = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) src[i] = 8'(8'hA0 + i);
        @(negedge clk);
        ivalid_v[0] = 1'b1;
        oready_v[0] = 1'b1;
        idata_v[0]  = units_at(0, 6);
        @(negedge clk);
        ivalid_v[0] = 1'b0;
        checks++;
        if (ovalid_v[0] !== 1'b1 || odata_v[0] !== 48'h0000_A3A2_A1A0) begin
            failures++;
            $display("FAIL mr_first ovalid=%b odata=%h exp 1/a3a2a1a0", ovalid_v[0], odata_v[0]);
        end
        oready_v[0] = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_all();
        test_reset();
        test_ordering();
        test_backpressure();
        test_simultaneous();
        test_mid_reset();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_upack.md
Name: ad_upack

Overview:
- Stream unpacker: accepts words of I_W units, emits words of O_W units, preserving unit order.
- Unit 0 sits in the LSBs and is sent first.
- Mirror of the packer stage. Sits between a wide DMA/FIFO source and a narrower channel consumer.
- Valid/ready handshake on both sides, with buffering to absorb rate mismatch.

Parameters:
- I_W, 6: input word width in units.
- O_W, 4: output word width in units. Any I_W/O_W ratio is legal, including I_W < O_W.
- UNIT_W, 8: unit width in bits.
- localparam BUF_U = 2*(I_W+O_W): buffer depth in units.
- localparam CNT_W = $clog2(BUF_U+1).

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-low.
- idata, input, I_W*UNIT_W: input word.
- ivalid, input, 1: idata valid.
- iready, output, 1: block can accept idata this cycle.
- odata, output, O_W*UNIT_W: output word.
- ovalid, output, 1: odata valid.
- oready, input, 1: consumer accepts odata.

Behaviour:
- State:
  - unit buffer buf[BUF_U], where buf[0] is the oldest unit;
  - unit count cnt (CNT_W bits).
- Reset (reset==0, async assert, sync release):
  - cnt=0 and all buf units = 0;
  - so ovalid=0, iready=1, odata=0.
- ifire = ivalid & iready; ofire = ovalid & oready.
- iready = (cnt <= BUF_U-I_W).
  - Decoded from registered cnt only. No combinational path from oready or ivalid.
- ovalid = (cnt >= O_W).
- odata = buf[0 +: O_W], taken directly from registers. No combinational path from idata.
- Per rising edge, evaluated in this order:
  - ofire: shift buf down by O_W units; vacated top units become don't-care.
  - ifire: write idata units 0..I_W-1 into buf[cnt' .. cnt'+I_W-1], where cnt' = cnt - (ofire ? O_W : 0).
  - cnt <= cnt + (ifire ? I_W : 0) - (ofire ? O_W : 0).
- Simultaneous ifire and ofire is legal. Input lands directly after the remaining units, with no bubble.
- Latency: input accepted at edge N with cnt+I_W >= O_W gives ovalid=1 in the cycle after edge N.
- Holding rules:
  - odata and ovalid stay stable while ovalid=1 and oready=0.
  - idata is ignored when ifire=0.
- Boundaries:
  - cnt never exceeds BUF_U and never underflows; ofire requires cnt >= O_W.
  - Residual cnt < O_W units are held indefinitely. There is no flush; residue is dropped only by reset.
  - Reset mid-operation discards all buffered units. The first word after release starts at output unit 0.
  - ivalid during reset is ignored.
- Written as buf/cnt registers plus a combinational next-state block. No other FSM is needed beyond cnt.

Decomposition:
- No shared package. All constants are local to the module, derived from parameters.
- Optional sub-module ad_upack_shift: buffer shift and insert datapath, parameterised on BUF_U/I_W/O_W/UNIT_W, with cnt logic kept in the top.
- The single-module form is preferred: the estimate is about 150 lines.

Test Plan:
- Parameters for all scenarios: I_W=6, O_W=4, UNIT_W=8 unless stated.
- Ordering: oready=1. Feed words with bytes 0..5, 6..11, 12..17, then 18..23, with ivalid=1 continuously.
  - Outputs are 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c, 0x13121110, 0x17161514.
  - No unit lost or duplicated.
- Backpressure: oready=0, ivalid=1 continuously.
  - Exactly 3 words are accepted (cnt 0→6→12→18), then iready=0.
  - odata holds 0x03020100.
  - Raising oready drains 4 words; iready returns when cnt <= 14.
- Simultaneous fire at cnt=14 with ivalid=1 and oready=1 gives cnt=16 next cycle.
  - The next odata is the correct units, proving the shift+insert order.
- Reset mid-stream: after one accepted word (cnt=6), pull reset low asynchronously between edges.
  - ovalid=0 and iready=1 immediately.
  - After release, input bytes 0xA0..0xA5 produce 0xA3A2A1A0 first.
- Random stall soak with 1024 random bytes:
  - Drive ivalid and oready as random 50% patterns.
  - Collected output equals input for all floor(1024/4)*4 bytes.
- Ratio variants: rerun the ordering and soak tests with I_W=4/O_W=6 and I_W=O_W=4.
  - For I_W=O_W=4, the 1:1 case passes words unchanged at full rate once primed.
